// File: rtl/vga_timing_gen.sv
// VGA raster timing source: free-running column/row counters with registered
// active-window syncs, porch-adjusted pin syncs, aligned counts, line/frame
// strobes and a wrapping frame counter. All outputs lag the counters by one
// clock and always describe the same (col,row) position.
module vga_timing_gen #(
    parameter int unsigned c_TOTAL_COLS      = 800,
    parameter int unsigned c_TOTAL_ROWS      = 525,
    parameter int unsigned c_ACTIVE_COLS     = 640,
    parameter int unsigned c_ACTIVE_ROWS     = 480,
    parameter int unsigned c_H_FRONT_PORCH   = 16,
    parameter int unsigned c_H_SYNC_WIDTH    = 96,
    parameter int unsigned c_V_FRONT_PORCH   = 10,
    parameter int unsigned c_V_SYNC_WIDTH    = 2,
    parameter bit          c_SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic       o_HSync_Pin,
    output logic       o_VSync_Pin,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Video_Active,
    output logic       o_Line_Start,
    output logic       o_Frame_Start,
    output logic [7:0] o_Frame_Count
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned FC_W  = 8;
    // One extra bit so bounds equal to 1024 still compare correctly.
    localparam int unsigned CMP_W = CNT_W + 1;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(c_TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(c_TOTAL_ROWS - 1);

    localparam logic [CMP_W-1:0] H_ACTIVE_END = CMP_W'(c_ACTIVE_COLS);
    localparam logic [CMP_W-1:0] V_ACTIVE_END = CMP_W'(c_ACTIVE_ROWS);
    localparam logic [CMP_W-1:0] H_PULSE_BEG  = CMP_W'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
    localparam logic [CMP_W-1:0] H_PULSE_END  = CMP_W'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH);
    localparam logic [CMP_W-1:0] V_PULSE_BEG  = CMP_W'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
    localparam logic [CMP_W-1:0] V_PULSE_END  = CMP_W'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH);

    localparam logic PIN_IDLE   = c_SYNC_ACTIVE_LOW;
    localparam logic PIN_ASSERT = !c_SYNC_ACTIVE_LOW;

    // Reject geometries whose sync pulse would run past the end of the line/frame.
    if (c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH > c_TOTAL_COLS) begin : g_bad_h_geom
        $error("vga_timing_gen: active + front porch + sync width exceeds total columns");
    end
    if (c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH > c_TOTAL_ROWS) begin : g_bad_v_geom
        $error("vga_timing_gen: active + front porch + sync width exceeds total rows");
    end
    if (c_TOTAL_COLS > 1024 || c_TOTAL_ROWS > 1024) begin : g_bad_size
        $error("vga_timing_gen: totals must fit the 10-bit counters");
    end

    // Raster position (r_Col / r_Row).
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;

    // Registered outputs.
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hpin_q, hpin_d;
    logic             vpin_q, vpin_d;
    logic [CNT_W-1:0] col_out_q, col_out_d;
    logic [CNT_W-1:0] row_out_q, row_out_d;
    logic             active_q, active_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;

    // Combinational decode of the current (pre-increment) position.
    logic [CMP_W-1:0] col_ext_c;
    logic [CMP_W-1:0] row_ext_c;
    logic             h_active_c;
    logic             v_active_c;
    logic             h_pulse_c;
    logic             v_pulse_c;

    // Position decode shared by every registered output.
    always_comb begin
        col_ext_c  = {1'b0, col_q};
        row_ext_c  = {1'b0, row_q};
        h_active_c = (col_ext_c < H_ACTIVE_END);
        v_active_c = (row_ext_c < V_ACTIVE_END);
        h_pulse_c  = (col_ext_c >= H_PULSE_BEG) && (col_ext_c < H_PULSE_END);
        v_pulse_c  = (row_ext_c >= V_PULSE_BEG) && (row_ext_c < V_PULSE_END);
    end

    // Raster counter advance: column wraps into a row step, row wraps with it.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (i_Enable) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + CNT_W'(1);
                end
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    // Next output values: levels hold and strobes drop while disabled.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        hpin_d        = hpin_q;
        vpin_d        = vpin_q;
        col_out_d     = col_out_q;
        row_out_d     = row_out_q;
        active_d      = active_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        if (i_Enable) begin
            hsync_d       = h_active_c;
            vsync_d       = v_active_c;
            hpin_d        = h_pulse_c ? PIN_ASSERT : PIN_IDLE;
            vpin_d        = v_pulse_c ? PIN_ASSERT : PIN_IDLE;
            col_out_d     = col_q;
            row_out_d     = row_q;
            active_d      = h_active_c && v_active_c;
            line_start_d  = (col_q == '0);
            frame_start_d = (col_q == '0) && (row_q == '0);
            if ((col_q == '0) && (row_q == '0)) begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            col_q         <= '0;
            row_q         <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hpin_q        <= PIN_IDLE;
            vpin_q        <= PIN_IDLE;
            col_out_q     <= '0;
            row_out_q     <= '0;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hpin_q        <= hpin_d;
            vpin_q        <= vpin_d;
            col_out_q     <= col_out_d;
            row_out_q     <= row_out_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign o_HSync        = hsync_q;
    assign o_VSync        = vsync_q;
    assign o_HSync_Pin    = hpin_q;
    assign o_VSync_Pin    = vpin_q;
    assign o_Col_Count    = col_out_q;
    assign o_Row_Count    = row_out_q;
    assign o_Video_Active = active_q;
    assign o_Line_Start   = line_start_q;
    assign o_Frame_Start  = frame_start_q;
    assign o_Frame_Count  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (active-low and active-high pins)
// on a shrunken raster, compared against a linear-position frame model.
module tb_vga_timing_gen;

    localparam int TC    = 16;
    localparam int TR    = 9;
    localparam int AC    = 10;
    localparam int AR    = 5;
    localparam int HFP   = 2;
    localparam int HSW   = 3;
    localparam int VFP   = 1;
    localparam int VSW   = 2;
    localparam int FRAME = TC * TR;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       hp;
        logic       vp;
        logic       va;
        logic       ls;
        logic       fs;
        logic [9:0] col;
        logic [9:0] row;
        logic [7:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic en;

    logic       lo_hs, lo_vs, lo_hp, lo_vp, lo_va, lo_ls, lo_fs;
    logic [9:0] lo_col, lo_row;
    logic [7:0] lo_fc;
    logic       hi_hs, hi_vs, hi_hp, hi_vp, hi_va, hi_ls, hi_fs;
    logic [9:0] hi_col, hi_row;
    logic [7:0] hi_fc;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_pos;
    obs_t m_out;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .c_TOTAL_COLS(TC), .c_TOTAL_ROWS(TR), .c_ACTIVE_COLS(AC), .c_ACTIVE_ROWS(AR),
        .c_H_FRONT_PORCH(HFP), .c_H_SYNC_WIDTH(HSW), .c_V_FRONT_PORCH(VFP),
        .c_V_SYNC_WIDTH(VSW), .c_SYNC_ACTIVE_LOW(1'b1)
    ) dut_lo (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
        .o_HSync(lo_hs), .o_VSync(lo_vs), .o_HSync_Pin(lo_hp), .o_VSync_Pin(lo_vp),
        .o_Col_Count(lo_col), .o_Row_Count(lo_row), .o_Video_Active(lo_va),
        .o_Line_Start(lo_ls), .o_Frame_Start(lo_fs), .o_Frame_Count(lo_fc)
    );

    vga_timing_gen #(
        .c_TOTAL_COLS(TC), .c_TOTAL_ROWS(TR), .c_ACTIVE_COLS(AC), .c_ACTIVE_ROWS(AR),
        .c_H_FRONT_PORCH(HFP), .c_H_SYNC_WIDTH(HSW), .c_V_FRONT_PORCH(VFP),
        .c_V_SYNC_WIDTH(VSW), .c_SYNC_ACTIVE_LOW(1'b0)
    ) dut_hi (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
        .o_HSync(hi_hs), .o_VSync(hi_vs), .o_HSync_Pin(hi_hp), .o_VSync_Pin(hi_vp),
        .o_Col_Count(hi_col), .o_Row_Count(hi_row), .o_Video_Active(hi_va),
        .o_Line_Start(hi_ls), .o_Frame_Start(hi_fs), .o_Frame_Count(hi_fc)
    );

    function automatic obs_t get_lo();
        return '{hs: lo_hs, vs: lo_vs, hp: lo_hp, vp: lo_vp, va: lo_va, ls: lo_ls,
                 fs: lo_fs, col: lo_col, row: lo_row, fc: lo_fc};
    endfunction

    function automatic obs_t get_hi();
        return '{hs: hi_hs, vs: hi_vs, hp: hi_hp, vp: hi_vp, va: hi_va, ls: hi_ls,
                 fs: hi_fs, col: hi_col, row: hi_row, fc: hi_fc};
    endfunction

    // Expected active-high-pin view of an active-low expectation.
    function automatic obs_t to_hi(input obs_t o);
        obs_t r;
        r    = o;
        r.hp = ~o.hp;
        r.vp = ~o.vp;
        return r;
    endfunction

    // Outputs for linear frame position pos, from the raster rules directly.
    function automatic obs_t decode(input int pos, input logic [7:0] fc);
        obs_t o;
        int   c;
        int   r;
        c     = pos % TC;
        r     = pos / TC;
        o.col = 10'(c);
        o.row = 10'(r);
        o.hs  = (c < AC);
        o.vs  = (r < AR);
        o.va  = (c < AC) && (r < AR);
        o.hp  = !((c >= AC + HFP) && (c < AC + HFP + HSW));
        o.vp  = !((r >= AR + VFP) && (r < AR + VFP + VSW));
        o.ls  = (c == 0);
        o.fs  = (pos == 0);
        o.fc  = fc;
        return o;
    endfunction

    function automatic obs_t reset_lo();
        obs_t o;
        o    = '0;
        o.hp = 1'b1;
        o.vp = 1'b1;
        return o;
    endfunction

    task automatic model_reset();
        m_pos = 0;
        m_out = reset_lo();
    endtask

    task automatic model_clock(input logic e);
        logic [7:0] nfc;
        if (e) begin
            nfc   = (m_pos == 0) ? 8'(m_out.fc + 8'd1) : m_out.fc;
            m_out = decode(m_pos, nfc);
            m_pos = (m_pos + 1) % FRAME;
        end else begin
            m_out.ls = 1'b0;
            m_out.fs = 1'b0;
        end
    endtask

    // One clock: drive enable, advance the model at the edge, sample 1ns later.
    task automatic tick(input logic e);
        en = e;
        @(posedge clk);
        if (rst) model_reset();
        else model_clock(e);
        #1;
    endtask

    task automatic test_reset();
        obs_t g;
        rst = 1'b1;
        en  = 1'b0;
        model_reset();
        repeat (3) tick(1'b1);
        g = get_lo();
        n_checks++;
        if (g !== reset_lo()) begin
            n_fail++;
            $display("FAIL reset_lo got=%h exp=%h", g, reset_lo());
        end
        g = get_hi();
        n_checks++;
        if (g !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_hi got=%h exp=%h", g, obs_t'(0));
        end
    endtask

    task automatic test_first_cycle();
        obs_t g;
        rst = 1'b0;
        tick(1'b1);
        g = get_lo();
        n_checks++;
        if ({g.col, g.row, g.hs, g.vs, g.ls, g.fs, g.fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL first_cycle got=%h", g);
        end
        n_checks++;
        if (g !== m_out) begin
            n_fail++;
            $display("FAIL first_cycle_model got=%h exp=%h", g, m_out);
        end
    endtask

    // Two full frames with per-cycle checks and per-frame aggregate counts.
    task automatic test_full_frame();
        obs_t g;
        obs_t h;
        int   va_cnt = 0;
        int   hp_low = 0;
        int   vp_low = 0;
        int   ls_cnt = 0;
        int   fs_at  = -1;
        int   last_ls = 0;
        int   ls_bad = 0;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            tick(1'b1);
            g = get_lo();
            h = get_hi();
            n_checks++;
            if (g !== m_out) begin
                n_fail++;
                $display("FAIL frame_lo i=%0d got=%h exp=%h", i, g, m_out);
            end
            n_checks++;
            if (h !== to_hi(m_out)) begin
                n_fail++;
                $display("FAIL frame_hi i=%0d got=%h exp=%h", i, h, to_hi(m_out));
            end
            if (i <= FRAME) begin
                va_cnt += int'(g.va);
                hp_low += int'(!g.hp);
                vp_low += int'(!g.vp);
                ls_cnt += int'(g.ls);
                if (g.fs && fs_at < 0) fs_at = i;
            end
            if (g.ls) begin
                if (i - last_ls != TC) ls_bad++;
                last_ls = i;
            end
        end
        n_checks++;
        if (va_cnt != AC * AR) begin
            n_fail++;
            $display("FAIL video_active_count got=%0d exp=%0d", va_cnt, AC * AR);
        end
        n_checks++;
        if (hp_low != HSW * TR || vp_low != VSW * TC) begin
            n_fail++;
            $display("FAIL pin_low_counts got=%0d/%0d exp=%0d/%0d", hp_low, vp_low, HSW * TR, VSW * TC);
        end
        n_checks++;
        if (fs_at != FRAME || ls_cnt != TR) begin
            n_fail++;
            $display("FAIL strobe_spacing fs_at=%0d exp=%0d ls_cnt=%0d exp=%0d", fs_at, FRAME, ls_cnt, TR);
        end
        n_checks++;
        if (ls_bad != 0) begin
            n_fail++;
            $display("FAIL line_start_period bad=%0d exp=0", ls_bad);
        end
    endtask

    // Hold enable low while the outputs show the last position of the frame.
    task automatic test_enable_hold_wrap();
        obs_t g;
        obs_t held;
        int   n = 0;
        while (!(m_out.col == 10'(TC - 1) && m_out.row == 10'(TR - 1)) && n < 2 * FRAME) begin
            tick(1'b1);
            n++;
        end
        g = get_lo();
        n_checks++;
        if (g.col !== 10'(TC - 1) || g.row !== 10'(TR - 1)) begin
            n_fail++;
            $display("FAIL hold_reach got=%0d,%0d exp=%0d,%0d", g.col, g.row, TC - 1, TR - 1);
        end
        held = g;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            g = get_lo();
            n_checks++;
            if (g !== held || g !== m_out) begin
                n_fail++;
                $display("FAIL hold_idle i=%0d got=%h exp=%h", i, g, held);
            end
        end
        tick(1'b1);
        g = get_lo();
        n_checks++;
        if ({g.col, g.row, g.fs, g.ls, g.fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 8'(held.fc + 8'd1)}) begin
            n_fail++;
            $display("FAIL hold_resume got=%h held_fc=%0d", g, held.fc);
        end
    endtask

    task automatic test_random_enable();
        obs_t g;
        obs_t h;
        logic e;
        for (int i = 0; i < 1500; i++) begin
            e = ($urandom_range(0, 3) != 0);
            tick(e);
            g = get_lo();
            h = get_hi();
            n_checks++;
            if (g !== m_out || h !== to_hi(m_out)) begin
                n_fail++;
                $display("FAIL rand_en i=%0d lo=%h hi=%h exp=%h", i, g, h, m_out);
            end
        end
    endtask

    // Asynchronous reset asserted mid-cycle while both pins are pulsing.
    task automatic test_async_reset();
        obs_t g;
        int   n = 0;
        while (!(m_out.col == 10'(AC + HFP + 1) && m_out.row == 10'(AR + VFP)) && n < 2 * FRAME) begin
            tick(1'b1);
            n++;
        end
        g = get_lo();
        n_checks++;
        if ({g.hp, g.vp} !== 2'b00 || g !== m_out) begin
            n_fail++;
            $display("FAIL pre_reset_pulse got=%h exp=%h", g, m_out);
        end
        #2;
        rst = 1'b1;
        #1;
        g = get_lo();
        n_checks++;
        if (g !== reset_lo()) begin
            n_fail++;
            $display("FAIL async_reset_lo got=%h exp=%h", g, reset_lo());
        end
        g = get_hi();
        n_checks++;
        if (g !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL async_reset_hi got=%h exp=%h", g, obs_t'(0));
        end
        model_reset();
        tick(1'b1);
        rst = 1'b0;
        tick(1'b1);
        g = get_lo();
        n_checks++;
        if (g !== m_out || g.fc !== 8'd1 || g.fs !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_first got=%h exp=%h", g, m_out);
        end
    endtask

    // Run past 256 frame starts and catch the 255 -> 0 wrap on a frame start.
    task automatic test_frame_count_wrap();
        obs_t g;
        logic [7:0] prev_fc;
        int   seen = 0;
        prev_fc = get_lo().fc;
        for (int i = 0; i < 257 * FRAME && seen == 0; i++) begin
            tick(1'b1);
            g = get_lo();
            n_checks++;
            if (g !== m_out) begin
                n_fail++;
                $display("FAIL wrap_run i=%0d got=%h exp=%h", i, g, m_out);
            end
            if (m_out.fs && m_out.fc == 8'd0) begin
                seen = 1;
                n_checks++;
                if ({g.fs, g.fc, prev_fc} !== {1'b1, 8'd0, 8'd255}) begin
                    n_fail++;
                    $display("FAIL fc_wrap got fs=%0b fc=%0d prev=%0d exp 1/0/255", g.fs, g.fc, prev_fc);
                end
            end
            prev_fc = g.fc;
        end
        n_checks++;
        if (seen == 0) begin
            n_fail++;
            $display("FAIL fc_wrap_seen got=0 exp=1");
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        test_reset();
        test_first_cycle();
        test_full_frame();
        test_enable_hold_wrap();
        test_random_enable();
        test_async_reset();
        test_frame_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
